hdmi_test_pattern: RTL and testbench
====================================

// Module: hdmi_test_pattern
// PURPOSE
// Video source directly upstream of hdmi: consumes cx/cy and the frame/screen geometry
// that hdmi reports, and produces the registered 24-bit rgb for hdmi's rgb input.
// Offers five test patterns: border, colour bars, checker, gradient and a bouncing box.
// Patterns are selected manually or auto-cycled. Pattern and motion state change only on
// frame boundaries, so a frame never tears.
// PARAMETERS
// BIT_WIDTH          10   width of cx, frame_width, screen_width
// BIT_HEIGHT         10   width of cy, frame_height, screen_height
// FRAMES_PER_PATTERN 120  auto-cycle dwell in frames; >=1
// BOX_SIZE           32   bouncing box edge, pixels
// BOX_STEP           2    box move per frame per axis, pixels; < BOX_SIZE
// PORTS
// clk_pixel      in   1          pixel clock, same clock as hdmi clk_pixel
// reset_n        in   1          asynchronous active-low reset
// cx             in   BIT_WIDTH  current x from hdmi
// cy             in   BIT_HEIGHT current y from hdmi
// frame_width    in   BIT_WIDTH  total x incl. blanking
// frame_height   in   BIT_HEIGHT total y incl. blanking
// screen_width   in   BIT_WIDTH  active x
// screen_height  in   BIT_HEIGHT active y
// pattern_sel    in   3          manual pattern, used when auto_cycle=0
// auto_cycle     in   1          1 = advance pattern every FRAMES_PER_PATTERN frames
// rgb            out  24         {R,G,B} for pixel (cx,cy), registered
// pattern_id     out  3          pattern currently displayed
// frame_start    out  1          1-cycle pulse aligned with rgb of pixel (0,0)
// BEHAVIOUR
// - Reset values: rgb=0, pattern_id=0, frame_start=0, box at (0,0) moving +x/+y,
//   dwell counter=0, frame counter=0. Reset is legal mid-frame; output is black until
//   the first clock after release.
// - Latency: rgb, frame_start = f(cx,cy) one cycle after cx,cy are presented; no stalls.
// - Active area: cx<screen_width && cy<screen_height; outside it rgb=0.
// - Frame-end event (FE): cx==frame_width-1 && cy==frame_height-1. All of the following
//   update on FE and take effect from pixel (0,0): frame_count+1 (8 bit, wraps),
//   pattern_id, box position, bar_w.
// - Pattern on FE:
//   - auto_cycle=0: pattern_id <= pattern_sel; dwell counter cleared.
//   - auto_cycle=1: dwell+1. At FRAMES_PER_PATTERN-1, dwell clears and pattern_id
//     advances 0>1>2>3>4>0; if pattern_id is >4, it goes to 0.
//   - auto_cycle toggling 0->1 continues from the current pattern_id with dwell=0.
// - Patterns (active area):
//   - 0 BORDER: R=FF if cx==0; G=FF if cy==0; B=FF if cx==screen_width-1 or
//     cy==screen_height-1; channels combine.
//   - 1 BARS: 8 bars white,yellow,cyan,green,magenta,red,blue,black; bar_w=screen_width>>3
//     latched on FE. A within-bar counter clears at cx==0 and advances the bar index on
//     reaching bar_w-1; index saturates at 7 (remainder columns are black). Uses no divider.
//     bar_w==0 -> all black.
//   - 2 CHECKER: FFFFFF if cx[5]^cy[5] else 000000.
//   - 3 GRADIENT: {cx[7:0], cy[7:0], frame_count}.
//   - 4 BOX: FFFFFF inside [bx,bx+BOX_SIZE) x [by,by+BOX_SIZE), else 0000FF.
//   - 5..7: 808080.
// - Box motion on FE, per axis, always running (not only while pattern 4 is shown).
//   The x and y axes update independently; a corner hit reverses both.
//   - Moving +: if pos+BOX_SIZE+BOX_STEP > screen dim, reverse and pos -= BOX_STEP,
//     else pos += BOX_STEP.
//   - Moving -: if pos < BOX_STEP, reverse and pos += BOX_STEP, else pos -= BOX_STEP.
//   - Screen dim <= BOX_SIZE+BOX_STEP on an axis -> that axis holds at 0.
// - Width rules: comparisons are done at BIT_WIDTH+1 / BIT_HEIGHT+1 bits so that
//   pos+BOX_SIZE+BOX_STEP cannot overflow.
// STRUCTURE
// - hdmi_test_pattern_pkg: pattern_t enum (BORDER, BARS, CHECKER, GRADIENT, BOX), the
//   8-entry bar colour table, and constants BLACK/WHITE/GREY/BLUE as logic [23:0].
// - Sub-module hdmi_test_pattern_box: box position/direction registers, updated on the
//   fe strobe. Inputs: screen dims, fe. Outputs: bx, by.
// - Top: FE decode, dwell/pattern FSM, bar counter, output mux and register.
// TESTING
// - Reset mid-frame, release -> rgb=0 and pattern_id=0 at release; pattern 0 is correct
//   from the first clock after release.
// - 640x480 geometry (frame 800x525), pattern_sel=1 -> cx=0..79 FFFFFF, cx=80 FFFF00,
//   cx=560..639 000000, cx>=640 000000.
// - auto_cycle=1, FRAMES_PER_PATTERN=2 -> pattern_id 0,0,1,1,2,2,3,3,4,4,0; each change
//   coincides with a frame_start pulse.
// - Pattern 4 over 310 frames, BOX_SIZE=32, BOX_STEP=2 -> bx reaches 608 and reverses to
//   606; by reaches 448 and reverses; pixel (bx,by) reads FFFFFF, pixel (bx-1,by) reads
//   0000FF.
// - pattern_sel changed 1->2 mid-frame -> rest of frame stays bars; next frame is checker
//   from pixel (0,0).
// - Pattern 3 over 256 frames -> B of pixel (0,0) steps 00..FF and wraps to 00.

Source files
------------

// File: rtl/hdmi_test_pattern_pkg.sv
// Shared types and colour constants for the HDMI test pattern source.
// Pattern codes, bar colour table and fixed colours.
package hdmi_test_pattern_pkg;

  typedef enum logic [2:0] {
    BORDER   = 3'd0,
    BARS     = 3'd1,
    CHECKER  = 3'd2,
    GRADIENT = 3'd3,
    BOX      = 3'd4
  } pattern_t;

  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] GREY  = 24'h808080;
  localparam logic [23:0] BLUE  = 24'h0000FF;

  // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
  localparam logic [7:0][23:0] BAR_TABLE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/hdmi_test_pattern_box.sv
// Bouncing box position, stepped once per frame-end strobe.
// Each axis bounces independently inside the active screen area.
module hdmi_test_pattern_box #(
  parameter int BIT_WIDTH  = 10,
  parameter int BIT_HEIGHT = 10,
  parameter int BOX_SIZE   = 32,
  parameter int BOX_STEP   = 2
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  input  logic [BIT_WIDTH-1:0]  screen_width,
  input  logic [BIT_HEIGHT-1:0] screen_height,
  input  logic                  fe,
  output logic [BIT_WIDTH-1:0]  bx,
  output logic [BIT_HEIGHT-1:0] by
);

  localparam logic [BIT_WIDTH:0]  XS = (BIT_WIDTH+1)'(BOX_SIZE);
  localparam logic [BIT_WIDTH:0]  XT = (BIT_WIDTH+1)'(BOX_STEP);
  localparam logic [BIT_HEIGHT:0] YS = (BIT_HEIGHT+1)'(BOX_SIZE);
  localparam logic [BIT_HEIGHT:0] YT = (BIT_HEIGHT+1)'(BOX_STEP);

  logic [BIT_WIDTH:0]    px, sw;
  logic [BIT_HEIGHT:0]   py, sh;
  logic [BIT_WIDTH-1:0]  bx_n;
  logic [BIT_HEIGHT-1:0] by_n;
  logic                  dx, dy, dx_n, dy_n;

  // Direction bit: 0 = moving +, 1 = moving -.
  always_comb begin
    px   = {1'b0, bx};
    py   = {1'b0, by};
    sw   = {1'b0, screen_width};
    sh   = {1'b0, screen_height};
    bx_n = bx;
    by_n = by;
    dx_n = dx;
    dy_n = dy;
    if (sw <= XS + XT) begin
      bx_n = '0;
      dx_n = 1'b0;
    end else if (!dx) begin
      if (px + XS + XT > sw) begin
        dx_n = 1'b1;
        bx_n = BIT_WIDTH'(px - XT);
      end else begin
        bx_n = BIT_WIDTH'(px + XT);
      end
    end else if (px < XT) begin
      dx_n = 1'b0;
      bx_n = BIT_WIDTH'(px + XT);
    end else begin
      bx_n = BIT_WIDTH'(px - XT);
    end
    if (sh <= YS + YT) begin
      by_n = '0;
      dy_n = 1'b0;
    end else if (!dy) begin
      if (py + YS + YT > sh) begin
        dy_n = 1'b1;
        by_n = BIT_HEIGHT'(py - YT);
      end else begin
        by_n = BIT_HEIGHT'(py + YT);
      end
    end else if (py < YT) begin
      dy_n = 1'b0;
      by_n = BIT_HEIGHT'(py + YT);
    end else begin
      by_n = BIT_HEIGHT'(py - YT);
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      bx <= '0;
      by <= '0;
      dx <= 1'b0;
      dy <= 1'b0;
    end else if (fe) begin
      bx <= bx_n;
      by <= by_n;
      dx <= dx_n;
      dy <= dy_n;
    end
  end

endmodule

// File: rtl/hdmi_test_pattern.sv
// Test pattern video source feeding hdmi: border, bars, checker,
// gradient and bouncing box, switched only on frame boundaries.
module hdmi_test_pattern #(
  parameter int BIT_WIDTH          = 10,
  parameter int BIT_HEIGHT         = 10,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int BOX_SIZE           = 32,
  parameter int BOX_STEP           = 2
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic [BIT_WIDTH-1:0]  frame_width,
  input  logic [BIT_HEIGHT-1:0] frame_height,
  input  logic [BIT_WIDTH-1:0]  screen_width,
  input  logic [BIT_HEIGHT-1:0] screen_height,
  input  logic [2:0]            pattern_sel,
  input  logic                  auto_cycle,
  output logic [23:0]           rgb,
  output logic [2:0]            pattern_id,
  output logic                  frame_start
);

  import hdmi_test_pattern_pkg::*;

  localparam int DW = $clog2(FRAMES_PER_PATTERN + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(FRAMES_PER_PATTERN - 1);
  localparam logic [BIT_WIDTH:0]  BSX = (BIT_WIDTH+1)'(BOX_SIZE);
  localparam logic [BIT_HEIGHT:0] BSY = (BIT_HEIGHT+1)'(BOX_SIZE);

  logic                  fe, origin, active, in_box;
  logic [2:0]            pat;
  logic [DW-1:0]         dwell;
  logic [7:0]            frame_count;
  logic [BIT_WIDTH-1:0]  bar_w, bar_cnt, cur_cnt;
  logic [2:0]            bar_idx, cur_idx;
  logic [BIT_WIDTH-1:0]  bx;
  logic [BIT_HEIGHT-1:0] by;
  logic [23:0]           color;

  assign fe = (cx == frame_width - 1'b1) &&
              (cy == frame_height - 1'b1);
  assign origin = (cx == '0) && (cy == '0);
  assign active = (cx < screen_width) && (cy < screen_height);

  hdmi_test_pattern_box #(
    .BIT_WIDTH (BIT_WIDTH),
    .BIT_HEIGHT(BIT_HEIGHT),
    .BOX_SIZE  (BOX_SIZE),
    .BOX_STEP  (BOX_STEP)
  ) u_box (
    .clk_pixel    (clk_pixel),
    .reset_n      (reset_n),
    .screen_width (screen_width),
    .screen_height(screen_height),
    .fe           (fe),
    .bx           (bx),
    .by           (by)
  );

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      pat         <= 3'd0;
      dwell       <= '0;
      frame_count <= '0;
      bar_w       <= '0;
    end else if (fe) begin
      frame_count <= frame_count + 8'd1;
      bar_w       <= screen_width >> 3;
      if (!auto_cycle) begin
        pat   <= pattern_sel;
        dwell <= '0;
      end else if (dwell == DWELL_LAST) begin
        dwell <= '0;
        pat   <= (pat >= 3'd4) ? 3'd0 : pat + 3'd1;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // Bar index tracks the scan without a divider; cx==0 restarts it.
  always_comb begin
    cur_cnt = (cx == '0) ? '0 : bar_cnt;
    cur_idx = (cx == '0) ? 3'd0 : bar_idx;
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      bar_cnt <= '0;
      bar_idx <= 3'd0;
    end else if (cur_cnt == bar_w - 1'b1) begin
      bar_cnt <= '0;
      bar_idx <= (cur_idx == 3'd7) ? cur_idx : cur_idx + 3'd1;
    end else begin
      bar_cnt <= cur_cnt + 1'b1;
      bar_idx <= cur_idx;
    end
  end

  assign in_box = ({1'b0, cx} >= {1'b0, bx}) &&
                  ({1'b0, cx} <  {1'b0, bx} + BSX) &&
                  ({1'b0, cy} >= {1'b0, by}) &&
                  ({1'b0, cy} <  {1'b0, by} + BSY);

  always_comb begin
    color = GREY;
    case (pat)
      BORDER: color = {
        (cx == '0) ? 8'hFF : 8'h00,
        (cy == '0) ? 8'hFF : 8'h00,
        ((cx == screen_width - 1'b1) ||
         (cy == screen_height - 1'b1)) ? 8'hFF : 8'h00
      };
      BARS:     color = (bar_w == '0) ? BLACK : BAR_TABLE[cur_idx];
      CHECKER:  color = (cx[5] ^ cy[5]) ? WHITE : BLACK;
      GRADIENT: color = {cx[7:0], cy[7:0], frame_count};
      BOX:      color = in_box ? WHITE : BLUE;
      default:  color = GREY;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rgb         <= BLACK;
      pattern_id  <= 3'd0;
      frame_start <= 1'b0;
    end else begin
      rgb         <= active ? color : BLACK;
      pattern_id  <= pat;
      frame_start <= origin;
    end
  end

endmodule

// File: tb/tb_hdmi_test_pattern.sv
// Directed bench for hdmi_test_pattern at 640x480 in an 800x525 frame.
// Frames are shortened to the pixels of interest plus one frame-end pixel.
module tb_hdmi_test_pattern;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  cx = 10'd700;
  logic [9:0]  cy = 10'd500;
  logic [9:0]  frame_width = 10'd800;
  logic [9:0]  frame_height = 10'd525;
  logic [9:0]  screen_width = 10'd640;
  logic [9:0]  screen_height = 10'd480;
  logic [2:0]  pattern_sel = 3'd2;
  logic        auto_cycle = 1'b0;
  logic [23:0] rgb;
  logic [2:0]  pattern_id;
  logic        frame_start;

  hdmi_test_pattern #(
    .BIT_WIDTH(10), .BIT_HEIGHT(10), .FRAMES_PER_PATTERN(2),
    .BOX_SIZE(32), .BOX_STEP(2)
  ) dut (
    .clk_pixel(clk), .reset_n(reset_n), .cx(cx), .cy(cy),
    .frame_width(frame_width), .frame_height(frame_height),
    .screen_width(screen_width), .screen_height(screen_height),
    .pattern_sel(pattern_sel), .auto_cycle(auto_cycle),
    .rgb(rgb), .pattern_id(pattern_id), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        fs;
  } vec_t;

  int total = 0;
  int bad = 0;
  int fe_count = 0;
  int mbx, mby;
  logic mdx, mdy;
  logic [23:0] s_rgb;
  logic        s_fs;
  logic [2:0]  s_pid;
  logic [23:0] bar_col [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
    24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string name, input logic [23:0] act,
                       input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic present(input int x, input int y);
    @(negedge clk);
    cx = 10'(x);
    cy = 10'(y);
  endtask

  task automatic frame_end();
    present(799, 524);
    fe_count++;
    if (!mdx) begin
      if (mbx + 34 > 640) begin mdx = 1'b1; mbx -= 2; end
      else mbx += 2;
    end else if (mbx < 2) begin mdx = 1'b0; mbx += 2; end
    else mbx -= 2;
    if (!mdy) begin
      if (mby + 34 > 480) begin mdy = 1'b1; mby -= 2; end
      else mby += 2;
    end else if (mby < 2) begin mdy = 1'b0; mby += 2; end
    else mby -= 2;
  endtask

  task automatic sample(input int x, input int y);
    present(x, y);
    @(negedge clk);
    s_rgb = rgb;
    s_fs = frame_start;
    s_pid = pattern_id;
    cx = 10'd700;
    cy = 10'd500;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("reset_rgb", rgb, 24'h0);
    check("reset_pid", {21'h0, pattern_id}, 24'h0);
    check("reset_fs", {23'h0, frame_start}, 24'h0);
    @(negedge clk);
    reset_n = 1'b1;
    check("release_rgb", rgb, 24'h0);
    check("release_pid", {21'h0, pattern_id}, 24'h0);
    cx = 10'd0;
    cy = 10'd5;
    fe_count = 0;
    mbx = 0; mby = 0; mdx = 1'b0; mdy = 1'b0;
    @(negedge clk);
    check("first_after_release", rgb, 24'hFF0000);
    cx = 10'd700;
    cy = 10'd500;
  endtask

  function automatic logic [23:0] exp_px(input int mode, input int x,
                                         input int y);
    if (x >= 640 || y >= 480) return 24'h0;
    if (mode == 1) return bar_col[x / 80];
    return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
  endfunction

  task automatic scan_row(input int y, input int xmax, input int mode,
                          input int sw_at, input string name);
    for (int x = 0; x <= xmax + 1; x++) begin
      @(negedge clk);
      if (x > 0) check(name, rgb, exp_px(mode, x - 1, y));
      if (x <= xmax) begin
        cx = 10'(x);
        cy = 10'(y);
        if (x == sw_at) pattern_sel = 3'd2;
      end else begin
        cx = 10'd700;
        cy = 10'd500;
      end
    end
  endtask

  vec_t border_v [10];
  int   seq_exp;

  initial begin
    border_v[0] = '{0, 5, 24'hFF0000, 1'b0};
    border_v[1] = '{5, 0, 24'h00FF00, 1'b0};
    border_v[2] = '{0, 0, 24'hFFFF00, 1'b1};
    border_v[3] = '{639, 10, 24'h0000FF, 1'b0};
    border_v[4] = '{10, 479, 24'h0000FF, 1'b0};
    border_v[5] = '{639, 479, 24'h0000FF, 1'b0};
    border_v[6] = '{0, 479, 24'hFF00FF, 1'b0};
    border_v[7] = '{10, 10, 24'h000000, 1'b0};
    border_v[8] = '{640, 0, 24'h000000, 1'b0};
    border_v[9] = '{0, 480, 24'h000000, 1'b0};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Checker running, then reset in the middle of a frame.
    frame_end();
    sample(40, 0);
    check("pre_reset_checker", s_rgb, 24'hFFFFFF);
    present(41, 0);
    pattern_sel = 3'd0;
    do_reset();

    foreach (border_v[i]) begin
      sample(border_v[i].x, border_v[i].y);
      check("border_rgb", s_rgb, border_v[i].rgb);
      check("border_fs", {23'h0, s_fs}, {23'h0, border_v[i].fs});
    end
    check("border_pid", {21'h0, s_pid}, 24'h0);

    // Colour bars, then a mid-frame switch to checker.
    pattern_sel = 3'd1;
    frame_end();
    scan_row(0, 799, 1, -1, "bars_row0");
    scan_row(1, 799, 1, 100, "bars_switch_row");
    frame_end();
    scan_row(0, 79, 2, -1, "checker_row0");
    sample(0, 0);
    check("checker_pid", {21'h0, s_pid}, 24'h2);

    // Auto-cycle with a two-frame dwell.
    pattern_sel = 3'd0;
    auto_cycle = 1'b1;
    do_reset();
    sample(0, 0);
    check("auto_pid", {21'h0, s_pid}, 24'h0);
    for (int i = 1; i <= 10; i++) begin
      seq_exp = (i / 2) % 5;
      present(799, 524);
      fe_count++;
      @(negedge clk);
      check("auto_pid_before", {21'h0, pattern_id},
            24'(((i - 1) / 2) % 5));
      check("auto_fs_before", {23'h0, frame_start}, 24'h0);
      cx = 10'd0;
      cy = 10'd0;
      @(negedge clk);
      check("auto_pid", {21'h0, pattern_id}, 24'(seq_exp));
      check("auto_fs", {23'h0, frame_start}, 24'h1);
      cx = 10'd700;
      cy = 10'd500;
    end
    auto_cycle = 1'b0;

    // Gradient: frame counter in blue, wraps after 256 frames.
    pattern_sel = 3'd3;
    frame_end();
    sample(5, 7);
    check("gradient_px", s_rgb, {8'h05, 8'h07, 8'(fe_count)});
    for (int i = 0; i < 257; i++) begin
      sample(0, 0);
      check("gradient_b", s_rgb, {16'h0, 8'(fe_count)});
      frame_end();
    end

    // Bouncing box over 310 frames.
    pattern_sel = 3'd4;
    do_reset();
    for (int n = 1; n <= 310; n++) begin
      frame_end();
      sample(mbx, mby);
      check("box_corner", s_rgb, 24'hFFFFFF);
      if (mbx > 0) begin
        sample(mbx - 1, mby);
        check("box_left", s_rgb, 24'h0000FF);
      end
      sample(mbx + 31, mby + 31);
      check("box_far", s_rgb, 24'hFFFFFF);
      if (n == 224) begin
        sample(mbx, 479);
        check("box_y448", s_rgb, 24'hFFFFFF);
      end
      if (n == 225) begin
        sample(mbx, 478);
        check("box_y446", s_rgb, 24'h0000FF);
      end
      if (n == 304) begin
        sample(639, mby);
        check("box_x608_in", s_rgb, 24'hFFFFFF);
        sample(607, mby);
        check("box_x608_out", s_rgb, 24'h0000FF);
      end
      if (n == 305) begin
        sample(606, mby);
        check("box_x606_in", s_rgb, 24'hFFFFFF);
        sample(638, mby);
        check("box_x606_out", s_rgb, 24'h0000FF);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
